// File: rtl/scdaq_pkg.sv
// Shared types and default sizing for the single-channel DAQ readout path.
package scdaq_pkg;

  localparam int NSAMPLES_DEF     = 512;
  localparam int PRECISION_DEF    = 14;
  localparam int RDO_ADD_BLEN_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_STREAM,
    ST_RELEASE
  } rdo_state_t;

endpackage

// File: rtl/scdaq_rdo_skid.sv
// Two-entry skid FIFO carrying {index, last, data} towards the output stream.
// The head entry drives the stream outputs directly; flush discards everything.
module scdaq_rdo_skid #(
  parameter int DW = 24
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [1:0]    o_occ,
  output logic          o_valid,
  output logic [DW-1:0] o_dout
);

  logic [DW-1:0] r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_occ   = r_count;
  assign o_valid = (r_count != 2'd0);
  assign o_dout  = r_mem[r_rptr];

endmodule

// File: rtl/scdaq_rdo_master.sv
// Readout initiator: requests a frame from the channel buffer, reads addresses
// 0..NSAMPLES-1 and streams the samples out with index/last tags.
//
// state      | meaning
// IDLE       | no transaction, waiting for Start or Continuous
// REQUEST    | RDO_Req high, waiting for the buffer to acknowledge
// STREAM     | issuing addresses, capturing samples, streaming them out
// RELEASE    | RDO_Req low, waiting for the buffer to drop RDO_Ack
module scdaq_rdo_master
  import scdaq_pkg::*;
#(
  parameter int NSAMPLES     = NSAMPLES_DEF,
  parameter int PRECISION    = PRECISION_DEF,
  parameter int RDO_ADD_BLEN = RDO_ADD_BLEN_DEF
) (
  input  logic                    i_RDO_Clock,
  input  logic                    i_Reset_n,
  input  logic                    i_Start,
  input  logic                    i_Continuous,
  output logic                    o_Busy,
  output logic                    o_Error,
  output logic                    o_RDO_Req,
  input  logic                    i_RDO_Ack,
  output logic [RDO_ADD_BLEN-1:0] o_RDO_Add,
  input  logic [PRECISION-1:0]    i_RDO_Q,
  output logic                    o_RDO_Done,
  output logic [PRECISION-1:0]    o_Out_Data,
  output logic [RDO_ADD_BLEN-1:0] o_Out_Index,
  output logic                    o_Out_Last,
  output logic                    o_Out_Valid,
  input  logic                    i_Out_Ready
);

  localparam int DW = RDO_ADD_BLEN + 1 + PRECISION;

  rdo_state_t              r_state;
  rdo_state_t              w_next;
  logic [RDO_ADD_BLEN:0]   r_idx;
  logic [RDO_ADD_BLEN-1:0] r_add;
  logic                    r_f1;
  logic                    r_f2;
  logic [RDO_ADD_BLEN-1:0] r_f2_idx;
  logic                    r_done;
  logic                    r_err;

  logic                    w_issue;
  logic                    w_capture;
  logic                    w_abort;
  logic                    w_xfer;
  logic                    w_last_xfer;
  logic                    w_all_issued;
  logic [2:0]              w_pending;
  logic                    w_room;
  logic [1:0]              w_occ;
  logic                    w_skid_valid;
  logic [DW-1:0]           w_skid_din;
  logic [DW-1:0]           w_head;

  assign w_xfer       = w_skid_valid & i_Out_Ready;
  assign w_last_xfer  = w_xfer & o_Out_Last;
  assign w_all_issued = r_idx[RDO_ADD_BLEN];

  // r_f1: address on RDO_Add, sample arrives next cycle.
  // r_f2: sample sitting on RDO_Q. RDO_Add is held while no new address is
  // issued, so an uncaptured sample stays on RDO_Q and acts as a third slot;
  // that is what lets the 2-entry skid sustain one sample per cycle.
  assign w_pending = 3'(w_occ) + 3'(r_f1) + 3'(r_f2);
  assign w_room    = (w_pending - 3'(w_xfer)) <= 3'd2;

  always_ff @(posedge i_RDO_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_Start || i_Continuous) w_next = ST_REQUEST;
      end
      ST_REQUEST: begin
        if (i_RDO_Ack) begin
          w_issue = 1'b1;
          w_next  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_last_xfer) begin
          w_next = ST_RELEASE;
        end else if (!i_RDO_Ack) begin
          w_abort = 1'b1;
          w_next  = ST_RELEASE;
        end else begin
          w_issue   = !w_all_issued && w_room;
          w_capture = r_f2 && ((w_occ != 2'd2) || w_xfer);
        end
      end
      ST_RELEASE: begin
        if (!i_RDO_Ack) w_next = i_Continuous ? ST_REQUEST : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_RDO_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_idx    <= '0;
      r_add    <= '0;
      r_f1     <= 1'b0;
      r_f2     <= 1'b0;
      r_f2_idx <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_last_xfer;
      r_err  <= w_abort;
      if (r_state == ST_IDLE || r_state == ST_RELEASE || w_abort) begin
        r_idx <= '0;
        r_f1  <= 1'b0;
        r_f2  <= 1'b0;
      end else begin
        if (w_issue) begin
          r_add <= r_idx[RDO_ADD_BLEN-1:0];
          r_idx <= r_idx + 1'b1;
        end
        r_f1 <= w_issue;
        if (r_f1) begin
          r_f2     <= 1'b1;
          r_f2_idx <= r_add;
        end else if (w_capture) begin
          r_f2 <= 1'b0;
        end
      end
    end
  end

  assign w_skid_din = {r_f2_idx, (r_f2_idx == RDO_ADD_BLEN'(NSAMPLES - 1)), i_RDO_Q};

  scdaq_rdo_skid #(
    .DW(DW)
  ) u_skid (
    .i_clk   (i_RDO_Clock),
    .i_rst_n (i_Reset_n),
    .i_flush (w_abort),
    .i_push  (w_capture),
    .i_din   (w_skid_din),
    .i_pop   (w_xfer),
    .o_occ   (w_occ),
    .o_valid (w_skid_valid),
    .o_dout  (w_head)
  );

  assign o_Out_Valid = w_skid_valid;
  assign o_Out_Data  = w_head[PRECISION-1:0];
  assign o_Out_Last  = w_head[PRECISION];
  assign o_Out_Index = w_head[DW-1 -: RDO_ADD_BLEN];
  assign o_RDO_Add   = r_add;
  assign o_RDO_Req   = (r_state == ST_REQUEST) || (r_state == ST_STREAM);
  assign o_Busy      = (r_state != ST_IDLE);
  assign o_RDO_Done  = r_done;
  assign o_Error     = r_err;

endmodule

// File: tb/tb_scdaq_rdo_master.sv
// Bench for scdaq_rdo_master: buffer model with randomized frame contents,
// random stream back-pressure and a frame-level expectation model.
module tb_scdaq_rdo_master;

  localparam int NS = 512;
  localparam int PW = 14;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n, start, cont, ack, ready;
  logic req, busy, err, done, valid, last;
  logic [AW-1:0] add, oidx;
  logic [PW-1:0] q, odata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [PW-1:0] buf_mem [NS];
  int ack_delay = 20;
  int rel_delay = 2;
  bit drop_req = 1'b0;
  bit ready_rand = 1'b0;

  // expectation model
  bit in_frame = 0, need_ack_low = 0, exp_done = 0, exp_err = 0;
  bit exp_invalid = 0, prev_stall = 0, first_pending = 0;
  logic [AW+PW:0] prev_word;
  int exp_idx = 0, start_cyc = 0, last_cyc = 0, frame_xfers = 0;
  int frames_done = 0, done_pulses = 0, err_pulses = 0, aborts = 0, xfer_total = 0;

  scdaq_rdo_master dut (
    .i_RDO_Clock  (clk),
    .i_Reset_n    (rst_n),
    .i_Start      (start),
    .i_Continuous (cont),
    .o_Busy       (busy),
    .o_Error      (err),
    .o_RDO_Req    (req),
    .i_RDO_Ack    (ack),
    .o_RDO_Add    (add),
    .i_RDO_Q      (q),
    .o_RDO_Done   (done),
    .o_Out_Data   (odata),
    .o_Out_Index  (oidx),
    .o_Out_Last   (last),
    .o_Out_Valid  (valid),
    .i_Out_Ready  (ready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // buffer: acknowledges a request with fresh random contents, releases after Req drops
  initial begin
    int cnt;
    cnt = 0;
    ack = 1'b0;
    for (int i = 0; i < NS; i++) buf_mem[i] = '0;
    forever begin
      @(posedge clk); #1;
      if (!ack) begin
        if (req) begin
          if (cnt >= ack_delay) begin
            for (int i = 0; i < NS; i++) buf_mem[i] = PW'($urandom_range(0, (1 << PW) - 1));
            ack = 1'b1;
            cnt = 0;
          end else cnt++;
        end else cnt = 0;
      end else if (!req) begin
        if (cnt >= rel_delay) begin
          ack = 1'b0;
          cnt = 0;
        end else cnt++;
      end else begin
        cnt = 0;
        if (drop_req) begin
          ack = 1'b0;
          drop_req = 1'b0;
        end
      end
    end
  end

  // buffer read port: one-cycle latency from address
  initial begin
    logic [AW-1:0] add_q;
    add_q = '0;
    q = '0;
    forever begin
      @(negedge clk);
      add_q = add;
      @(posedge clk); #1;
      q = buf_mem[add_q];
    end
  end

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // compare process: frame-level rules checked every cycle
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      in_frame = 0; need_ack_low = 0; exp_done = 0; exp_err = 0;
      exp_invalid = 0; prev_stall = 0; first_pending = 0; exp_idx = 0;
      chk("reset_outputs", {req, done, add, valid, last, odata, oidx, busy, err}, 0);
    end else begin
      if (done) done_pulses++;
      if (err) err_pulses++;
      chk("rdo_done", done, exp_done);
      chk("error", err, exp_err);
      if (exp_invalid || !in_frame) chk("valid_outside_frame", valid, 0);
      if (need_ack_low) chk("req_in_release", req, 0);
      if (in_frame || need_ack_low) chk("busy_in_frame", busy, 1);
      if (in_frame) chk("req_in_frame", req, 1);
      if (prev_stall) begin
        chk("stall_valid", valid, 1);
        chk("stall_hold", {oidx, last, odata}, prev_word);
      end
      exp_done = 0; exp_err = 0; exp_invalid = 0; prev_stall = 0;
      if (need_ack_low && !ack) need_ack_low = 0;
      if (in_frame) begin
        if (valid) begin
          if (first_pending) begin
            chk("first_valid_latency", cyc - start_cyc, 3);
            first_pending = 0;
          end
          chk("out_index", oidx, exp_idx);
          chk("out_data", odata, buf_mem[exp_idx]);
          chk("out_last", last, exp_idx == NS - 1);
          if (ready) begin
            frame_xfers++;
            xfer_total++;
            if (exp_idx == NS - 1) begin
              exp_done = 1; in_frame = 0; need_ack_low = 1;
              frames_done++; last_cyc = cyc;
            end
            exp_idx++;
          end else begin
            prev_stall = 1;
            prev_word = {oidx, last, odata};
          end
        end
        if (in_frame && !ack) begin
          exp_err = 1; exp_invalid = 1; in_frame = 0; need_ack_low = 1;
          prev_stall = 0; aborts++;
        end
      end else if (!need_ack_low && req && ack) begin
        in_frame = 1; exp_idx = 0; start_cyc = cyc; first_pending = 1; frame_xfers = 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    chk(name, frames_done, target);
  endtask

  task automatic wait_xfers(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (!(in_frame && frame_xfers >= target) && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    chk(name, n < budget, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int f0, d0, e0, a0, x0, n;
    rst_n = 1'b0; start = 1'b0; cont = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(3);

    // single frame, Out_Ready always high
    f0 = frames_done; d0 = done_pulses;
    pulse_start();
    wait_frames(f0 + 1, 2000, "t1_frame_done");
    chk("t1_xfers", frame_xfers, 512);
    chk("t1_span_ack_to_last", last_cyc - start_cyc, 514);
    idle(10);
    chk("t1_done_pulses", done_pulses - d0, 1);
    chk("t1_busy_after", busy, 0);

    // random back-pressure
    ready_rand = 1'b1;
    f0 = frames_done; d0 = done_pulses;
    pulse_start();
    wait_frames(f0 + 1, 4000, "t2_frame_done");
    chk("t2_xfers", frame_xfers, 512);
    ready_rand = 1'b0;
    idle(10);
    chk("t2_done_pulses", done_pulses - d0, 1);

    // continuous mode, three frames
    f0 = frames_done; d0 = done_pulses; x0 = xfer_total;
    @(posedge clk); #1 cont = 1'b1;
    n = 0;
    while (!(frames_done == f0 + 2 && in_frame) && n < 4000) begin
      @(negedge clk); #2;
      n++;
    end
    cont = 1'b0;
    wait_frames(f0 + 3, 2000, "t3_frames");
    idle(60);
    chk("t3_done_pulses", done_pulses - d0, 3);
    chk("t3_xfers", xfer_total - x0, 3 * 512);
    chk("t3_busy_after", busy, 0);
    chk("t3_no_extra_frame", frames_done - f0, 3);

    // Ack dropped mid-frame
    f0 = frames_done; d0 = done_pulses; e0 = err_pulses; a0 = aborts;
    pulse_start();
    wait_xfers(100, 2000, "t4_reach_100");
    drop_req = 1'b1;
    idle(40);
    chk("t4_error_pulses", err_pulses - e0, 1);
    chk("t4_aborts", aborts - a0, 1);
    chk("t4_no_done", done_pulses - d0, 0);
    chk("t4_no_frame", frames_done - f0, 0);
    chk("t4_busy_after", busy, 0);

    // asynchronous reset mid-frame
    pulse_start();
    wait_xfers(300, 2000, "t5_reach_300");
    rst_n = 1'b0;
    #1;
    chk("t5_reset_immediate", {req, done, add, valid, last, odata, oidx, busy, err}, 0);
    idle(3);
    rst_n = 1'b1;
    n = 0;
    while (ack && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_ack_released", ack, 0);
    f0 = frames_done;
    pulse_start();
    wait_frames(f0 + 1, 2000, "t5_fresh_frame");
    chk("t5_xfers", frame_xfers, 512);

    // Start while Busy is ignored
    idle(20);
    f0 = frames_done; d0 = done_pulses;
    pulse_start();
    idle(60);
    pulse_start();
    idle(200);
    pulse_start();
    wait_frames(f0 + 1, 2000, "t6_frame_done");
    idle(80);
    chk("t6_single_frame", frames_done - f0, 1);
    chk("t6_done_pulses", done_pulses - d0, 1);
    chk("t6_busy_after", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
